cordic_scheduler: RTL and testbench

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

---
 rtl/package_settings.sv | 28 ++
 rtl/cordic_scheduler_if.sv | 40 ++++
 rtl/cordic_resp_fifo.sv | 75 +++++++
 rtl/cordic_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_cordic_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/package_settings.sv
// ---------------------------------------------------------------------------
// package_settings
// Shared settings for the CORDIC datapath and its request scheduler.
//   FULL_SIZE      : operand / result width of the cordic kernel
//   CORDIC_LATENCY : kernel cycles from krn_enable to krn_out_valid
//   ID_W_MAX       : width of the requester id carried in a response entry
//   resp_entry_t   : one response FIFO entry {i, q, theta, id}
//   id_width()     : requester id width for a given requester count
// ---------------------------------------------------------------------------
package package_settings;

   localparam int FULL_SIZE      = 16;
   localparam int CORDIC_LATENCY = 4;
   localparam int ID_W_MAX       = 8;

   typedef struct packed {
      logic [FULL_SIZE-1:0] i;
      logic [FULL_SIZE-1:0] q;
      logic [FULL_SIZE-1:0] theta;
      logic [ID_W_MAX-1:0]  id;
   } resp_entry_t;

   // A single requester still needs a one-bit id field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// ---------------------------------------------------------------------------
// cordic_scheduler_if
// Requester and response handshake bundle of the cordic scheduler.
//   req_valid/req_ready       : per-requester request handshake
//   req_data_i/req_data_q     : per-requester operands
//   rsp_valid/rsp_ready       : response handshake
//   rsp_i/rsp_q/rsp_theta/id  : response fields and originating requester
// Modports: master = requesters + response consumer, slave = scheduler.
// ---------------------------------------------------------------------------
interface cordic_scheduler_if
   import package_settings::*;
#(
   parameter int NUM_REQ = 4
);

   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ-1:0][FULL_SIZE-1:0] req_data_i;
   logic [NUM_REQ-1:0][FULL_SIZE-1:0] req_data_q;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [FULL_SIZE-1:0] rsp_i;
   logic [FULL_SIZE-1:0] rsp_q;
   logic [FULL_SIZE-1:0] rsp_theta;
   logic [ID_W-1:0]      rsp_id;

   modport master (
      output req_valid, req_data_i, req_data_q, rsp_ready,
      input  req_ready, rsp_valid, rsp_i, rsp_q, rsp_theta, rsp_id
   );

   modport slave (
      input  req_valid, req_data_i, req_data_q, rsp_ready,
      output req_ready, rsp_valid, rsp_i, rsp_q, rsp_theta, rsp_id
   );

endinterface

// File: rtl/cordic_resp_fifo.sv
// ---------------------------------------------------------------------------
// cordic_resp_fifo
// First-word-fall-through response FIFO.
//   clk, reset : clock, synchronous active-high reset
//   push/data  : write request and entry (ignored when full without a pop)
//   pop        : read request (ignored when empty)
//   head       : current head entry, all-zero while empty
//   empty      : no entry stored
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cordic_resp_fifo #(
   parameter int  DEPTH   = 16,
   parameter type entry_t = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          empty_s;
   logic          full_s;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign empty_s   = (count_r == (AW+1)'(0));
   assign full_s    = (count_r == (AW+1)'(DEPTH));
   assign pop_ok_s  = pop & ~empty_s;
   // A push into a full FIFO is accepted only if a pop frees the slot.
   assign push_ok_s = push & (~full_s | pop_ok_s);

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = empty_s ? entry_t'('0) : mem_r[rd_ptr_r];
   assign empty = empty_s;
   assign count = count_r;

endmodule

// File: rtl/cordic_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_scheduler
// Shares one pipelined cordic kernel between NUM_REQ requesters and returns
// results in issue order through a response FIFO.
//   clk, reset          : clock, synchronous active-high reset (kernel too)
//   bus (slave)         : request handshakes/operands, response handshake
//   krn_data_i/q        : registered operands to the kernel
//   krn_enable          : registered kernel input valid
//   krn_out_i/q/theta   : kernel results
//   krn_out_valid       : kernel result valid
//   err_tag             : sticky flag, kernel valid disagreed with tag valid
// Configuration macro: CORDIC_SCHED_STRICT_PRIO_EN selects fixed priority
// (lowest index wins); without it arbitration is round-robin.
// Credit (RESP_DEPTH minus in-flight minus queued) ensures every issued
// operation has a reserved FIFO slot, so the kernel is never back-pressured.
// ---------------------------------------------------------------------------
module cordic_scheduler
   import package_settings::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int RESP_DEPTH  = 16,
   parameter int KRN_LATENCY = CORDIC_LATENCY
) (
   input  logic                 clk,
   input  logic                 reset,
   cordic_scheduler_if.slave    bus,
   output logic [FULL_SIZE-1:0] krn_data_i,
   output logic [FULL_SIZE-1:0] krn_data_q,
   output logic                 krn_enable,
   input  logic [FULL_SIZE-1:0] krn_out_i,
   input  logic [FULL_SIZE-1:0] krn_out_q,
   input  logic [FULL_SIZE-1:0] krn_out_theta,
   input  logic                 krn_out_valid,
   output logic                 err_tag
);

   localparam int ID_W = id_width(NUM_REQ);
   localparam int CW   = $clog2(RESP_DEPTH) + 1;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   logic [ID_W-1:0]      grant_idx_s;
   logic [ID_W-1:0]      cand_idx_s;
   logic                 grant_any_s;
   logic [NUM_REQ-1:0]   req_ready_s;
   logic                 xfer_s;
   logic [CW:0]          occupancy_s;
   logic                 credit_ok_s;
   logic [CW-1:0]        inflight_r;
   logic [CW-1:0]        fifo_count_s;
   logic                 krn_enable_r;
   logic [FULL_SIZE-1:0] krn_data_i_r;
   logic [FULL_SIZE-1:0] krn_data_q_r;
   logic [ID_W-1:0]      krn_id_r;
   tag_t                 tag_pipe_r [KRN_LATENCY];
   tag_t                 tag_out_s;
   logic                 err_tag_r;
   resp_entry_t          push_entry_s;
   resp_entry_t          head_s;
   logic                 empty_s;
   logic                 pop_s;
   logic                 unused_id_bits_s;

`ifdef CORDIC_SCHED_STRICT_PRIO_EN
   // Fixed priority: lowest-index valid requester wins.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      cand_idx_s  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand_idx_s = ID_W'(off);
         if (!grant_any_s && bus.req_valid[cand_idx_s]) begin
            grant_any_s = 1'b1;
            grant_idx_s = cand_idx_s;
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end
`else
   logic [ID_W-1:0] last_grant_r;

   // Round-robin: search starts just after the last granted requester.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      cand_idx_s  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand_idx_s = ID_W'((int'(last_grant_r) + off) % NUM_REQ);
         if (!grant_any_s && bus.req_valid[cand_idx_s]) begin
            grant_any_s = 1'b1;
            grant_idx_s = cand_idx_s;
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

   // Arbitration pointer, moves only when a request actually transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_r <= ID_W'(NUM_REQ - 1);
      end else if (xfer_s) begin
         last_grant_r <= grant_idx_s;
      end
   end
`endif

   assign occupancy_s = (CW+1)'(inflight_r) + (CW+1)'(fifo_count_s);
   assign credit_ok_s = (occupancy_s < (CW+1)'(RESP_DEPTH));

   // Ready is a pure function of valid, pointer and credit (no handshake loop).
   always_comb begin
      req_ready_s = '0;
      if (!reset && credit_ok_s && grant_any_s) begin
         req_ready_s[grant_idx_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign xfer_s        = |(bus.req_valid & req_ready_s);

   // Kernel launch register: operands hold when nothing transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         krn_enable_r <= 1'b0;
         krn_data_i_r <= '0;
         krn_data_q_r <= '0;
         krn_id_r     <= '0;
      end else begin
         krn_enable_r <= xfer_s;
         if (xfer_s) begin
            krn_data_i_r <= bus.req_data_i[grant_idx_s];
            krn_data_q_r <= bus.req_data_q[grant_idx_s];
            krn_id_r     <= grant_idx_s;
         end
      end
   end

   assign krn_enable = krn_enable_r;
   assign krn_data_i = krn_data_i_r;
   assign krn_data_q = krn_data_q_r;

   // Tag pipeline shadowing the kernel so each result gets its requester id.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < KRN_LATENCY; s++) begin
            tag_pipe_r[s] <= '0;
         end
      end else begin
         tag_pipe_r[0] <= '{valid: krn_enable_r, id: krn_id_r};
         for (int s = 1; s < KRN_LATENCY; s++) begin
            tag_pipe_r[s] <= tag_pipe_r[s-1];
         end
      end
   end

   assign tag_out_s = tag_pipe_r[KRN_LATENCY-1];

   // Sticky error when the kernel's valid disagrees with the expected tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_tag_r <= 1'b0;
      end else if (krn_out_valid != tag_out_s.valid) begin
         err_tag_r <= 1'b1;
      end else begin
         err_tag_r <= err_tag_r;
      end
   end

   assign err_tag = err_tag_r;

   // Operations issued but not yet returned by the kernel; a spurious
   // kernel valid must not wrap the counter below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_r <= '0;
      end else begin
         case ({xfer_s, krn_out_valid && (inflight_r != CW'(0))})
            2'b10:   inflight_r <= inflight_r + CW'(1);
            2'b01:   inflight_r <= inflight_r - CW'(1);
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Response entry assembled from the kernel result and its tag.
   always_comb begin
      push_entry_s       = '0;
      push_entry_s.i     = krn_out_i;
      push_entry_s.q     = krn_out_q;
      push_entry_s.theta = krn_out_theta;
      push_entry_s.id    = ID_W_MAX'(tag_out_s.id);
   end

   assign pop_s = ~empty_s & bus.rsp_ready;

   cordic_resp_fifo #(
      .DEPTH   (RESP_DEPTH),
      .entry_t (resp_entry_t)
   ) u_resp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (krn_out_valid),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (head_s),
      .empty     (empty_s),
      .count     (fifo_count_s)
   );

   assign bus.rsp_valid = ~empty_s;
   assign bus.rsp_i     = head_s.i;
   assign bus.rsp_q     = head_s.q;
   assign bus.rsp_theta = head_s.theta;
   assign bus.rsp_id    = head_s.id[ID_W-1:0];
   // Upper id bits are always zero for this requester count.
   assign unused_id_bits_s = ^head_s.id;

endmodule

// File: tb/tb_cordic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_scheduler
// Directed bench for cordic_scheduler with a behavioural kernel and a
// response scoreboard. Honours CORDIC_SCHED_STRICT_PRIO_EN for grant order.
// ---------------------------------------------------------------------------
module tb_cordic_scheduler;
   import package_settings::*;

   localparam int NUM_REQ    = 4;
   localparam int RESP_DEPTH = 16;
   localparam int L          = CORDIC_LATENCY;

   typedef struct {
      resp_entry_t ent;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic inj   = 1'b0;

   logic [FULL_SIZE-1:0] krn_data_i, krn_data_q;
   logic                 krn_enable;
   logic [FULL_SIZE-1:0] krn_out_i, krn_out_q, krn_out_theta;
   logic                 krn_out_valid;
   logic                 err_tag;

   logic                 kv [L];
   logic [FULL_SIZE-1:0] ka [L];
   logic [FULL_SIZE-1:0] kb [L];
   resp_entry_t          kout;

   exp_t sb[$];
   int   gq_id[$];
   int   gq_cyc[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   xfer_cnt = 0;
   int   pops = 0;
   int   rsp_seen = 0;
   bit   lat_chk = 1'b0;
   int   mon_id;
   exp_t mon_e;
   resp_entry_t got_e;

   cordic_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   cordic_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .RESP_DEPTH  (RESP_DEPTH),
      .KRN_LATENCY (L)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .krn_data_i    (krn_data_i),
      .krn_data_q    (krn_data_q),
      .krn_enable    (krn_enable),
      .krn_out_i     (krn_out_i),
      .krn_out_q     (krn_out_q),
      .krn_out_theta (krn_out_theta),
      .krn_out_valid (krn_out_valid),
      .err_tag       (err_tag)
   );

   always #5 clk = ~clk;

   // Behavioural kernel transfer function (stands in for the real cordic).
   function automatic resp_entry_t kmodel(input logic [FULL_SIZE-1:0] a,
                                          input logic [FULL_SIZE-1:0] b,
                                          input int id);
      resp_entry_t e;
      e.i     = a + b;
      e.q     = a - b;
      e.theta = a ^ (b << 3) ^ 16'h5A5A;
      e.id    = ID_W_MAX'(id);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req_valid = '0;
      tick();
      tick();
      reset = 1'b0;
      sb.delete();
      gq_id.delete();
      gq_cyc.delete();
      xfer_cnt = 0;
      pops = 0;
      rsp_seen = 0;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         tick();
         n++;
      end
      chk({"drain_", tag}, 64'(sb.size()), 64'd0);
   endtask

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Kernel model: fixed latency L, cleared by the shared reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < L; s++) begin
            kv[s] <= 1'b0;
            ka[s] <= '0;
            kb[s] <= '0;
         end
      end else begin
         kv[0] <= krn_enable;
         ka[0] <= krn_data_i;
         kb[0] <= krn_data_q;
         for (int s = 1; s < L; s++) begin
            kv[s] <= kv[s-1];
            ka[s] <= ka[s-1];
            kb[s] <= kb[s-1];
         end
      end
   end

   always_comb begin
      kout          = kmodel(ka[L-1], kb[L-1], 0);
      krn_out_i     = kout.i;
      krn_out_q     = kout.q;
      krn_out_theta = kout.theta;
      krn_out_valid = kv[L-1] | inj;
   end

   // Monitor: record transfers into the scoreboard, check popped responses.
   always @(negedge clk) begin
      if (!reset) begin
         chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
         if (|(bus.req_valid & bus.req_ready)) begin
            mon_id = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
               if (bus.req_ready[k]) mon_id = k;
            end
            sb.push_back('{ent: kmodel(bus.req_data_i[mon_id], bus.req_data_q[mon_id], mon_id),
                           cyc: cyc});
            gq_id.push_back(mon_id);
            gq_cyc.push_back(cyc);
            xfer_cnt++;
         end
         if (bus.rsp_valid) begin
            rsp_seen++;
            if (bus.rsp_ready) begin
               pops++;
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
               end else begin
                  mon_e       = sb.pop_front();
                  got_e.i     = bus.rsp_i;
                  got_e.q     = bus.rsp_q;
                  got_e.theta = bus.rsp_theta;
                  got_e.id    = ID_W_MAX'(bus.rsp_id);
                  chk("rsp_entry", 64'(got_e), 64'(mon_e.ent));
                  if (lat_chk) chk("latency", 64'(cyc - mon_e.cyc), 64'(L + 2));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = '0;
      bus.req_data_i = '0;
      bus.req_data_q = '0;
      bus.rsp_ready  = 1'b0;

      // Reset state, with every requester asserting valid.
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '1;
      for (int k = 0; k < NUM_REQ; k++) bus.req_data_i[k] = FULL_SIZE'(16'h1111 * (k + 1));
      @(negedge clk);
      chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
      chk("rst_krn_enable", 64'(krn_enable), 64'd0);
      chk("rst_krn_data_i", 64'(krn_data_i), 64'd0);
      chk("rst_krn_data_q", 64'(krn_data_q), 64'd0);
      chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_fields", 64'({bus.rsp_i, bus.rsp_q, bus.rsp_theta, bus.rsp_id}), 64'd0);
      chk("rst_err_tag",    64'(err_tag), 64'd0);
      tick();
      bus.req_valid = '0;
      reset = 1'b0;

      // Single request from requester 0, minimum latency.
      bus.rsp_ready     = 1'b1;
      lat_chk           = 1'b1;
      bus.req_data_i[0] = 16'd100;
      bus.req_data_q[0] = 16'd0;
      bus.req_valid[0]  = 1'b1;
      @(negedge clk);
      chk("t35_ready", 64'(bus.req_ready), 64'h1);
      tick();
      bus.req_valid = '0;
      wait_drain("t35", 40);
      chk("t35_xfers", 64'(xfer_cnt), 64'd1);
      chk("t35_pops", 64'(pops), 64'd1);

      // All four requesters valid: grant order and response order.
      do_reset();
      bus.req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_data_i[k] = FULL_SIZE'($urandom);
            bus.req_data_q[k] = FULL_SIZE'($urandom);
         end
         tick();
      end
      bus.req_valid = '0;
      chk("t36_xfers", 64'(gq_id.size()), 64'd6);
      for (int k = 0; k < gq_id.size(); k++) begin
`ifdef CORDIC_SCHED_STRICT_PRIO_EN
         chk("t36_grant", 64'(gq_id[k]), 64'd0);
`else
         chk("t36_grant", 64'(gq_id[k]), 64'(k % NUM_REQ));
`endif
         if (k > 0) chk("t36_consecutive", 64'(gq_cyc[k] - gq_cyc[k-1]), 64'd1);
      end
      wait_drain("t36", 40);
      chk("t36_pops", 64'(pops), 64'd6);

      // Requesters 0 and 2 held valid.
      do_reset();
      bus.req_valid = 4'b0101;
      for (int c = 0; c < 6; c++) begin
         bus.req_data_i[0] = FULL_SIZE'($urandom);
         bus.req_data_i[2] = FULL_SIZE'($urandom);
         tick();
      end
      bus.req_valid = '0;
      chk("t38_xfers", 64'(gq_id.size()), 64'd6);
      for (int k = 0; k < gq_id.size(); k++) begin
`ifdef CORDIC_SCHED_STRICT_PRIO_EN
         chk("t38_grant", 64'(gq_id[k]), 64'd0);
`else
         chk("t38_grant", 64'(gq_id[k]), 64'((k % 2) * 2));
`endif
      end
      wait_drain("t38", 40);

      // Back-pressure: credit limits transfers to RESP_DEPTH.
      do_reset();
      lat_chk       = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      for (int c = 0; c < 30; c++) begin
         bus.req_data_i[0] = FULL_SIZE'($urandom);
         bus.req_data_q[0] = FULL_SIZE'($urandom);
         tick();
      end
      chk("t37_xfers", 64'(xfer_cnt), 64'(RESP_DEPTH));
      @(negedge clk);
      chk("t37_ready_zero", 64'(bus.req_ready), 64'd0);
      chk("t37_head_a", 64'({bus.rsp_i, bus.rsp_q, bus.rsp_theta, 8'(bus.rsp_id)}),
          64'(sb[0].ent));
      tick();
      tick();
      @(negedge clk);
      chk("t37_head_b", 64'({bus.rsp_i, bus.rsp_q, bus.rsp_theta, 8'(bus.rsp_id)}),
          64'(sb[0].ent));
      tick();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      wait_drain("t37", 60);
      chk("t37_pops", 64'(pops), 64'(RESP_DEPTH));

      // Reset with 3 queued and 5 in flight: nothing survives.
      do_reset();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      repeat (3) tick();
      bus.req_valid = '0;
      repeat (L + 3) tick();
      bus.req_valid = 4'b0001;
      repeat (5) tick();
      chk("t39_xfers", 64'(xfer_cnt), 64'd8);
      reset         = 1'b1;
      bus.req_valid = '0;
      sb.delete();
      tick();
      reset    = 1'b0;
      rsp_seen = 0;
      pops     = 0;
      @(negedge clk);
      chk("t39_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      bus.rsp_ready = 1'b1;
      repeat (20) tick();
      chk("t39_no_stale", 64'(rsp_seen), 64'd0);

      // Spurious kernel valid: sticky err_tag until reset.
      do_reset();
      bus.rsp_ready = 1'b0;
      inj = 1'b1;
      @(negedge clk);
      chk("t40_err_before", 64'(err_tag), 64'd0);
      tick();
      inj = 1'b0;
      @(negedge clk);
      chk("t40_err_set", 64'(err_tag), 64'd1);
      chk("t40_push_follows_valid", 64'(bus.rsp_valid), 64'd1);
      repeat (5) tick();
      chk("t40_err_sticky", 64'(err_tag), 64'd1);
      do_reset();
      @(negedge clk);
      chk("t40_err_cleared", 64'(err_tag), 64'd0);
      chk("t40_rsp_cleared", 64'(bus.rsp_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
